register_file: RTL and testbench

- Architectural register file with rename-status tracking; sits directly downstream of the reorder buffer.
- Consumes the ROB's commit writes (value plus committing ROB id) and its dispatch-time dependency writes (destination register plus new ROB id).
- Presents each decoder source operand as either a resolved value or the ROB tag it waits on.
- Operands still in flight are resolved by querying the ROB's value ports.

---
 rtl/register_file_pkg.sv | 31 +++
 rtl/regfile_read_port.sv | 61 ++++++
 rtl/register_file.sv | 109 ++++++++++
 tb/tb_register_file.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// ============================================================================
// Module : register_file_pkg
// Brief  : Shared constants, operand-source encoding and helpers for the
//          architectural register file.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package register_file_pkg;

  localparam int C_ROBSIZE_W = 4;
  localparam int C_XLEN      = 32;
  localparam int C_NUM_REGS  = 32;
  localparam int C_REG_IDX_W = 5;

  // Which of the read-path priority steps produced the operand
  typedef enum logic [2:0] {
    SRC_ZERO   = 3'd0,
    SRC_REG    = 3'd1,
    SRC_BYPASS = 3'd2,
    SRC_ROB    = 3'd3,
    SRC_WAIT   = 3'd4
  } src_sel_e;

  function automatic logic writable(input logic [C_REG_IDX_W-1:0] rd);
    return rd != '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_read_port.sv
// ============================================================================
// Module : regfile_read_port
// Brief  : Zero-latency operand resolver: x0, register, commit bypass, ROB.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile_read_port
  import register_file_pkg::*;
#(
  parameter int ROB_ID_W = C_ROBSIZE_W,
  parameter int XLEN     = C_XLEN
) (
  input  logic [C_REG_IDX_W-1:0] rs,
  input  logic [XLEN-1:0]        reg_val,
  input  logic                   reg_busy,
  input  logic [ROB_ID_W-1:0]    reg_tag,
  input  logic                   commit_en,
  input  logic [C_REG_IDX_W-1:0] commit_rd,
  input  logic [XLEN-1:0]        commit_val,
  input  logic [ROB_ID_W-1:0]    commit_rob_id,
  input  logic                   rob_val_ready,
  input  logic [XLEN-1:0]        rob_val,
  output logic                   ready,
  output logic [XLEN-1:0]        val,
  output logic [ROB_ID_W-1:0]    tag
);

  src_sel_e w_sel;

  always_comb begin
    w_sel = SRC_WAIT;
    if (rs == '0)
      w_sel = SRC_ZERO;
    else if (!reg_busy)
      w_sel = SRC_REG;
    else if (commit_en && (commit_rd == rs) && (reg_tag == commit_rob_id))
      w_sel = SRC_BYPASS;
    else if (rob_val_ready)
      w_sel = SRC_ROB;
  end

  always_comb begin
    ready = 1'b1;
    val   = '0;
    tag   = '0;
    case (w_sel)
      SRC_ZERO:   val = '0;
      SRC_REG:    val = reg_val;
      SRC_BYPASS: val = commit_val;
      SRC_ROB:    val = rob_val;
      default: begin
        ready = 1'b0;
        tag   = reg_tag;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/register_file.sv
// ============================================================================
// Module : register_file
// Brief  : Architectural register file with ROB rename tracking and
//          two combinational source-operand ports.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module register_file
  import register_file_pkg::*;
#(
  parameter int ROB_ID_W = C_ROBSIZE_W,
  parameter int XLEN     = C_XLEN
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rdy,
  input  logic                   clear,
  input  logic                   commit_en,
  input  logic [C_REG_IDX_W-1:0] commit_rd,
  input  logic [XLEN-1:0]        commit_val,
  input  logic [ROB_ID_W-1:0]    commit_rob_id,
  input  logic                   dep_en,
  input  logic [C_REG_IDX_W-1:0] dep_rd,
  input  logic [ROB_ID_W-1:0]    dep_rob_id,
  input  logic [C_REG_IDX_W-1:0] rs1,
  input  logic [C_REG_IDX_W-1:0] rs2,
  output logic                   src1_ready,
  output logic                   src2_ready,
  output logic [XLEN-1:0]        src1_val,
  output logic [XLEN-1:0]        src2_val,
  output logic [ROB_ID_W-1:0]    src1_tag,
  output logic [ROB_ID_W-1:0]    src2_tag,
  output logic [ROB_ID_W-1:0]    q_rob_id1,
  output logic [ROB_ID_W-1:0]    q_rob_id2,
  input  logic                   rob_val1_ready,
  input  logic                   rob_val2_ready,
  input  logic [XLEN-1:0]        rob_val1,
  input  logic [XLEN-1:0]        rob_val2
);

  logic [XLEN-1:0]     r_val  [C_NUM_REGS];
  logic                r_busy [C_NUM_REGS];
  logic [ROB_ID_W-1:0] r_tag  [C_NUM_REGS];

  // The dep update follows the commit so it wins busy/tag on a shared register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        r_val[i]  <= '0;
        r_busy[i] <= 1'b0;
        r_tag[i]  <= '0;
      end
    end else if (rdy) begin
      if (clear) begin
        for (int i = 0; i < C_NUM_REGS; i++)
          r_busy[i] <= 1'b0;
      end else begin
        if (commit_en && writable(commit_rd)) begin
          r_val[commit_rd] <= commit_val;
          if (r_busy[commit_rd] && (r_tag[commit_rd] == commit_rob_id))
            r_busy[commit_rd] <= 1'b0;
        end
        if (dep_en && writable(dep_rd)) begin
          r_busy[dep_rd] <= 1'b1;
          r_tag[dep_rd]  <= dep_rob_id;
        end
      end
    end
  end

  assign q_rob_id1 = r_tag[rs1];
  assign q_rob_id2 = r_tag[rs2];

  regfile_read_port #(.ROB_ID_W(ROB_ID_W), .XLEN(XLEN)) u_port1 (
    .rs            (rs1),
    .reg_val       (r_val[rs1]),
    .reg_busy      (r_busy[rs1]),
    .reg_tag       (r_tag[rs1]),
    .commit_en     (commit_en),
    .commit_rd     (commit_rd),
    .commit_val    (commit_val),
    .commit_rob_id (commit_rob_id),
    .rob_val_ready (rob_val1_ready),
    .rob_val       (rob_val1),
    .ready         (src1_ready),
    .val           (src1_val),
    .tag           (src1_tag)
  );

  regfile_read_port #(.ROB_ID_W(ROB_ID_W), .XLEN(XLEN)) u_port2 (
    .rs            (rs2),
    .reg_val       (r_val[rs2]),
    .reg_busy      (r_busy[rs2]),
    .reg_tag       (r_tag[rs2]),
    .commit_en     (commit_en),
    .commit_rd     (commit_rd),
    .commit_val    (commit_val),
    .commit_rob_id (commit_rob_id),
    .rob_val_ready (rob_val2_ready),
    .rob_val       (rob_val2),
    .ready         (src2_ready),
    .val           (src2_val),
    .tag           (src2_tag)
  );

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// ============================================================================
// Module : tb_register_file
// Brief  : Directed bench for register_file with a behavioural reference.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_register_file;

  logic        clk = 1'b0;
  logic        rst_n, rdy, clear;
  logic        commit_en, dep_en;
  logic [4:0]  commit_rd, dep_rd, rs1, rs2;
  logic [31:0] commit_val, rob_val1, rob_val2;
  logic [3:0]  commit_rob_id, dep_rob_id;
  logic        rob_val1_ready, rob_val2_ready;
  logic        src1_ready, src2_ready;
  logic [31:0] src1_val, src2_val;
  logic [3:0]  src1_tag, src2_tag, q_rob_id1, q_rob_id2;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit checking  = 1'b0;

  register_file dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear),
    .commit_en(commit_en), .commit_rd(commit_rd), .commit_val(commit_val),
    .commit_rob_id(commit_rob_id), .dep_en(dep_en), .dep_rd(dep_rd),
    .dep_rob_id(dep_rob_id), .rs1(rs1), .rs2(rs2),
    .src1_ready(src1_ready), .src2_ready(src2_ready),
    .src1_val(src1_val), .src2_val(src2_val),
    .src1_tag(src1_tag), .src2_tag(src2_tag),
    .q_rob_id1(q_rob_id1), .q_rob_id2(q_rob_id2),
    .rob_val1_ready(rob_val1_ready), .rob_val2_ready(rob_val2_ready),
    .rob_val1(rob_val1), .rob_val2(rob_val2)
  );

  always #5 clk = ~clk;

  // Reference state: what each architectural register holds and who owns it
  logic [31:0] m_val  [32];
  bit          m_busy [32];
  logic [3:0]  m_tag  [32];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
      end
    end else if (rdy && clear) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 0;
    end else if (rdy) begin
      if (commit_en && commit_rd != 0) begin
        m_val[commit_rd] = commit_val;
        if (m_busy[commit_rd] && m_tag[commit_rd] == commit_rob_id)
          m_busy[commit_rd] = 0;
      end
      if (dep_en && dep_rd != 0) begin
        m_busy[dep_rd] = 1;
        m_tag[dep_rd]  = dep_rob_id;
      end
    end
  end

  typedef struct packed {
    logic        ready;
    logic [31:0] val;
    logic [3:0]  tag;
  } operand_t;

  function automatic operand_t model_read(input logic [4:0] rs,
                                          input logic rvr,
                                          input logic [31:0] rv);
    operand_t o;
    o = '{ready: 1'b1, val: 32'd0, tag: 4'd0};
    if (rs == 0)
      o.val = 0;
    else if (!m_busy[rs])
      o.val = m_val[rs];
    else if (commit_en && commit_rd == rs && m_tag[rs] == commit_rob_id)
      o.val = commit_val;
    else if (rvr)
      o.val = rv;
    else begin
      o.ready = 1'b0;
      o.tag   = m_tag[rs];
    end
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (checking) begin
      operand_t e1, e2;
      e1 = model_read(rs1, rob_val1_ready, rob_val1);
      e2 = model_read(rs2, rob_val2_ready, rob_val2);
      chk("m_src1_ready", {31'd0, src1_ready}, {31'd0, e1.ready});
      chk("m_src1_val",   src1_val,            e1.val);
      chk("m_src1_tag",   {28'd0, src1_tag},   {28'd0, e1.tag});
      chk("m_src2_ready", {31'd0, src2_ready}, {31'd0, e2.ready});
      chk("m_src2_val",   src2_val,            e2.val);
      chk("m_src2_tag",   {28'd0, src2_tag},   {28'd0, e2.tag});
      chk("m_q1", {28'd0, q_rob_id1}, {28'd0, m_tag[rs1]});
      chk("m_q2", {28'd0, q_rob_id2}, {28'd0, m_tag[rs2]});
    end
  end

  task automatic idle();
    clear = 0; commit_en = 0; commit_rd = 0; commit_val = 0; commit_rob_id = 0;
    dep_en = 0; dep_rd = 0; dep_rob_id = 0;
    rob_val1_ready = 0; rob_val2_ready = 0; rob_val1 = 0; rob_val2 = 0;
  endtask

  // Advance past the next rising edge, then set up a fresh idle cycle
  task automatic next();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic lit1(input string n, input logic r, input logic [31:0] v, input logic [3:0] t);
    chk({n, "_ready"}, {31'd0, src1_ready}, {31'd0, r});
    chk({n, "_val"}, src1_val, v);
    chk({n, "_tag"}, {28'd0, src1_tag}, {28'd0, t});
  endtask

  task automatic lit2(input string n, input logic r, input logic [31:0] v, input logic [3:0] t);
    chk({n, "_ready"}, {31'd0, src2_ready}, {31'd0, r});
    chk({n, "_val"}, src2_val, v);
    chk({n, "_tag"}, {28'd0, src2_tag}, {28'd0, t});
  endtask

  initial begin
    idle();
    rst_n = 0; rdy = 0; rs1 = 0; rs2 = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1; rdy = 1;
    checking = 1;

    rs1 = 5; rs2 = 0;
    settle(); lit1("rst_rs5", 1, 32'd0, 0); lit2("rst_rs0", 1, 32'd0, 0);

    next(); dep_en = 1; dep_rd = 3; dep_rob_id = 2;
    next(); rs1 = 3;
    settle(); lit1("wait_r3", 0, 32'd0, 4'd2);
    chk("q1_r3", {28'd0, q_rob_id1}, 32'd2);

    next(); commit_en = 1; commit_rd = 3; commit_val = 32'hDEAD; commit_rob_id = 2;
    settle(); lit1("bypass_r3", 1, 32'hDEAD, 0);
    next();
    settle(); lit1("after_commit_r3", 1, 32'hDEAD, 0);

    next(); dep_en = 1; dep_rd = 7; dep_rob_id = 1;
    next(); dep_en = 1; dep_rd = 7; dep_rob_id = 4;
    next(); commit_en = 1; commit_rd = 7; commit_val = 9; commit_rob_id = 1; rs2 = 7;
    settle(); lit2("stale_commit_r7", 0, 32'd0, 4'd4);
    next();
    settle(); lit2("still_busy_r7", 0, 32'd0, 4'd4);
    chk("q2_r7", {28'd0, q_rob_id2}, 32'd4);
    rob_val2_ready = 1; rob_val2 = 32'h55;
    settle(); lit2("rob_fwd_r7", 1, 32'h55, 0);

    next(); commit_en = 1; commit_rd = 8; commit_val = 32'h88; commit_rob_id = 5;
    dep_en = 1; dep_rd = 8; dep_rob_id = 6;
    next(); rs1 = 8;
    settle(); lit1("dep_wins_r8", 0, 32'd0, 4'd6);

    next(); dep_en = 1; dep_rd = 3; dep_rob_id = 3;
    next(); clear = 1; commit_en = 1; commit_rd = 3; commit_val = 32'h1234;
    commit_rob_id = 3; dep_en = 1; dep_rd = 9; dep_rob_id = 7;
    next(); rs1 = 3; rs2 = 7;
    settle(); lit1("clear_r3", 1, 32'hDEAD, 0); lit2("clear_r7", 1, 32'd9, 0);
    rs1 = 8; rs2 = 9;
    settle(); lit1("clear_r8", 1, 32'h88, 0); lit2("clear_dep_r9", 1, 32'd0, 0);

    next(); commit_en = 1; commit_rd = 0; commit_val = 1; dep_en = 1; dep_rd = 0;
    dep_rob_id = 5;
    next(); rs1 = 0; rs2 = 0;
    settle(); lit1("x0_a", 1, 32'd0, 0); lit2("x0_b", 1, 32'd0, 0);

    next(); rdy = 0; dep_en = 1; dep_rd = 10; dep_rob_id = 5;
    commit_en = 1; commit_rd = 11; commit_val = 32'h77; commit_rob_id = 1;
    next(); rdy = 1; rs1 = 10; rs2 = 11;
    settle(); lit1("hold_r10", 1, 32'd0, 0); lit2("hold_r11", 1, 32'd0, 0);

    next();
    checking = 0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
